// File: rtl/updi_byte_engine.sv
// Byte engine for a UPDI link: pushes a byte to the UART TX FIFO and checks its
// echo, or receives one byte, with a timeout and sticky RX error reporting.
module updi_byte_engine #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic       op_type,
    input  logic [7:0] op_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_status,
    output logic [7:0] uart_tx_data,
    output logic       uart_tx_wr_en,
    input  logic       uart_tx_full,
    input  logic [7:0] uart_rx_data,
    output logic       uart_rx_rd_en,
    input  logic       uart_rx_empty,
    input  logic       uart_rx_error,
    output logic       busy
);

    localparam logic [15:0] TIMER_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  ST_OK       = 2'b00;
    localparam logic [1:0]  ST_MISMATCH = 2'b01;
    localparam logic [1:0]  ST_TIMEOUT  = 2'b10;
    localparam logic [1:0]  ST_RX_ERROR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_TX,
        S_WAIT_RX,
        S_POP_RX,
        S_CAPTURE,
        S_RESPOND
    } state_t;

    state_t      state_q, state_d;
    logic        type_q, type_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] timer_q, timer_d;
    logic        err_q, err_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic [1:0]  rsp_status_q, rsp_status_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_wr_en_q, tx_wr_en_d;
    logic        rx_rd_en_q, rx_rd_en_d;
    logic        op_ready_q, op_ready_d;
    logic        busy_q, busy_d;
    logic        err_now;

    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        byte_d       = byte_q;
        timer_d      = timer_q;
        err_d        = err_q;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        tx_data_d    = tx_data_q;
        tx_wr_en_d   = 1'b0;
        rx_rd_en_d   = 1'b0;
        // The error flag is sticky from accept through capture, including this cycle.
        err_now      = err_q | uart_rx_error;

        case (state_q)
            S_IDLE: begin
                if (op_valid && op_ready_q) begin
                    type_d  = op_type;
                    byte_d  = op_data;
                    timer_d = 16'd0;
                    err_d   = uart_rx_error;
                    if (op_type) begin
                        state_d = S_WAIT_RX;
                    end else begin
                        tx_data_d = op_data;
                        state_d   = S_PUSH_TX;
                    end
                end
            end
            S_PUSH_TX: begin
                err_d = err_now;
                if (!uart_tx_full) begin
                    tx_wr_en_d = 1'b1;
                    state_d    = S_WAIT_RX;
                end
            end
            S_WAIT_RX: begin
                err_d = err_now;
                // Data present on the final timer count still takes the pop path.
                if (!uart_rx_empty) begin
                    rx_rd_en_d = 1'b1;
                    state_d    = S_POP_RX;
                end else if (timer_q == TIMER_LAST) begin
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = 8'h00;
                    rsp_status_d = err_now ? ST_RX_ERROR : ST_TIMEOUT;
                    state_d      = S_RESPOND;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_POP_RX: begin
                err_d   = err_now;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                err_d       = err_now;
                rsp_valid_d = 1'b1;
                rsp_data_d  = uart_rx_data;
                if (err_now) begin
                    rsp_status_d = ST_RX_ERROR;
                end else if (!type_q && (uart_rx_data != byte_q)) begin
                    rsp_status_d = ST_MISMATCH;
                end else begin
                    rsp_status_d = ST_OK;
                end
                state_d = S_RESPOND;
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        op_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            type_q       <= 1'b0;
            byte_q       <= 8'h00;
            timer_q      <= 16'd0;
            err_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 8'h00;
            rsp_status_q <= ST_OK;
            tx_data_q    <= 8'h00;
            tx_wr_en_q   <= 1'b0;
            rx_rd_en_q   <= 1'b0;
            op_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            byte_q       <= byte_d;
            timer_q      <= timer_d;
            err_q        <= err_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            tx_data_q    <= tx_data_d;
            tx_wr_en_q   <= tx_wr_en_d;
            rx_rd_en_q   <= rx_rd_en_d;
            op_ready_q   <= op_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign op_ready      = op_ready_q;
    assign busy          = busy_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_status    = rsp_status_q;
    assign uart_tx_data  = tx_data_q;
    assign uart_tx_wr_en = tx_wr_en_q;
    assign uart_rx_rd_en = rx_rd_en_q;

endmodule

// File: tb/tb_updi_byte_engine.sv
// Directed bench for updi_byte_engine: a vector table of single operations over a
// behavioural RX FIFO with loopback echo, plus reset and back-to-back sequences.
module tb_updi_byte_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic       op_type = 1'b0;
    logic [7:0] op_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [1:0] rsp_status;
    logic [7:0] uart_tx_data;
    logic       uart_tx_wr_en;
    logic       uart_tx_full = 1'b0;
    logic [7:0] uart_rx_data = 8'h00;
    logic       uart_rx_rd_en;
    logic       uart_rx_empty = 1'b1;
    logic       uart_rx_error = 1'b0;
    logic       busy;

    updi_byte_engine #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type), .op_data(op_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .uart_tx_data(uart_tx_data), .uart_tx_wr_en(uart_tx_wr_en), .uart_tx_full(uart_tx_full),
        .uart_rx_data(uart_rx_data), .uart_rx_rd_en(uart_rx_rd_en), .uart_rx_empty(uart_rx_empty),
        .uart_rx_error(uart_rx_error), .busy(busy)
    );

    always #5 clk = ~clk;

    // RX FIFO model with loopback: the echo byte is queued echo_delay edges after
    // the trigger (the accept edge or the TX push edge); delay 0 queues on the trigger edge.
    logic       echo_en = 1'b0;
    logic       echo_on_accept = 1'b0;
    int         echo_delay = 0;
    logic [7:0] echo_byte = 8'h00;
    logic       flush_req = 1'b0;
    logic [7:0] rx_q[$];
    logic       pend = 1'b0;
    int         cnt = 0;
    int         acc_cnt = 0;
    int         rsp_cnt = 0;
    int         wr_cnt = 0;
    int         rd_cnt = 0;

    always @(posedge clk) begin
        logic trig;
        if (op_valid && op_ready) acc_cnt++;
        if (rsp_valid) rsp_cnt++;
        if (uart_tx_wr_en) wr_cnt++;
        if (uart_rx_rd_en) rd_cnt++;
        if (flush_req) begin
            rx_q.delete();
            pend = 1'b0;
        end else begin
            if (uart_rx_rd_en && rx_q.size() > 0) uart_rx_data <= rx_q.pop_front();
            trig = echo_en && (echo_on_accept ? (op_valid && op_ready) : uart_tx_wr_en);
            if (trig) begin
                if (echo_delay == 0) rx_q.push_back(echo_byte);
                else begin
                    pend = 1'b1;
                    cnt  = echo_delay;
                end
            end else if (pend) begin
                if (cnt <= 1) begin
                    rx_q.push_back(echo_byte);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
        uart_rx_empty <= (rx_q.size() == 0);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // exp_cycle: cycle index (1 = first cycle after the accept edge) in which rsp_valid is high.
    // full_cycles: uart_tx_full held high in cycles 1..full_cycles; err_cycle: rx_error pulse cycle (0 = none).
    typedef struct {
        logic       op_type;
        logic [7:0] op_data;
        logic       echo_en;
        logic       echo_on_accept;
        int         echo_delay;
        logic [7:0] echo_byte;
        int         full_cycles;
        int         err_cycle;
        logic [7:0] exp_data;
        logic [1:0] exp_status;
        int         exp_cycle;
        int         exp_pops;
    } vec_t;

    vec_t vecs[11];

    task automatic flush_rx();
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        echo_en   = 1'b0;
    endtask

    task automatic run_op(input string tag, input vec_t v);
        int  n = 0;
        int  txc = 0;
        int  rdc = 0;
        int  push_cyc = 0;
        int  ready_bad = 0;
        logic got = 1'b0;
        logic [7:0] tx_byte = 8'h00;
        echo_en        = v.echo_en;
        echo_on_accept = v.echo_on_accept;
        echo_delay     = v.echo_delay;
        echo_byte      = v.echo_byte;
        op_type        = v.op_type;
        op_data        = v.op_data;
        uart_tx_full   = (v.full_cycles > 0);
        op_valid       = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        while (!got && n < 80) begin
            uart_tx_full  = (n + 1 <= v.full_cycles);
            uart_rx_error = (n + 1 == v.err_cycle);
            @(posedge clk); #1;
            n++;
            if (uart_tx_wr_en) begin
                txc++;
                push_cyc = n + 1;
                tx_byte  = uart_tx_data;
            end
            if (uart_rx_rd_en) rdc++;
            if (op_ready || !busy) ready_bad++;
            if (rsp_valid) got = 1'b1;
        end
        uart_tx_full  = 1'b0;
        uart_rx_error = 1'b0;
        check({tag, "_rsp_seen"}, 32'(got), 32'd1);
        check({tag, "_cycle"}, 32'(n + 1), 32'(v.exp_cycle));
        check({tag, "_data"}, 32'(rsp_data), 32'(v.exp_data));
        check({tag, "_status"}, 32'(rsp_status), 32'(v.exp_status));
        check({tag, "_pushes"}, 32'(txc), v.op_type ? 32'd0 : 32'd1);
        check({tag, "_pops"}, 32'(rdc), 32'(v.exp_pops));
        check({tag, "_ready_low"}, 32'(ready_bad), 32'd0);
        if (!v.op_type) begin
            check({tag, "_push_cycle"}, 32'(push_cyc), 32'(v.full_cycles + 2));
            check({tag, "_tx_byte"}, 32'(tx_byte), 32'(v.op_data));
        end
        @(posedge clk); #1;
        check({tag, "_rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(op_ready), 32'd1);
        check({tag, "_data_hold"}, 32'(rsp_data), 32'(v.exp_data));
        flush_rx();
    endtask

    initial begin
        int acc0;
        int rsp0;
        int wr0;
        int rd0;
        int ready_hi;
        int overlap;
        vec_t v;

        vecs[0]  = '{1'b0, 8'h55, 1'b1, 1'b0, 3,  8'h55, 0,  0, 8'h55, 2'b00, 9,  1};
        vecs[1]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 0,  8'hA4, 0,  0, 8'hA4, 2'b01, 5,  1};
        vecs[2]  = '{1'b0, 8'h5A, 1'b1, 1'b1, 0,  8'h5A, 0,  0, 8'h5A, 2'b00, 5,  1};
        vecs[3]  = '{1'b1, 8'h00, 1'b0, 1'b0, 0,  8'h00, 0,  0, 8'h00, 2'b10, 17, 0};
        vecs[4]  = '{1'b1, 8'h00, 1'b1, 1'b1, 2,  8'hC3, 0,  0, 8'hC3, 2'b00, 6,  1};
        vecs[5]  = '{1'b1, 8'h00, 1'b1, 1'b1, 15, 8'h7E, 0,  0, 8'h7E, 2'b00, 19, 1};
        vecs[6]  = '{1'b1, 8'h00, 1'b1, 1'b1, 16, 8'h11, 0,  0, 8'h00, 2'b10, 17, 0};
        vecs[7]  = '{1'b0, 8'h3C, 1'b1, 1'b0, 2,  8'h3C, 10, 4, 8'h3C, 2'b11, 18, 1};
        vecs[8]  = '{1'b0, 8'h80, 1'b1, 1'b1, 0,  8'h80, 0,  3, 8'h80, 2'b11, 5,  1};
        vecs[9]  = '{1'b1, 8'h00, 1'b0, 1'b0, 0,  8'h00, 0,  5, 8'h00, 2'b11, 17, 0};
        vecs[10] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1,  8'h00, 2,  0, 8'h00, 2'b01, 9,  1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_op_ready", 32'(op_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_tx_wr_en", 32'(uart_tx_wr_en), 32'd0);
        check("rst_rx_rd_en", 32'(uart_rx_rd_en), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_status", 32'(rsp_status), 32'd0);
        check("rst_tx_data", 32'(uart_tx_data), 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("v%0d", i), vecs[i]);
        end

        // Reset while in POP_RX abandons the receive
        echo_en = 1'b1; echo_on_accept = 1'b1; echo_delay = 0; echo_byte = 8'h99;
        op_type = 1'b1; op_data = 8'h00; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_in_pop", 32'(uart_rx_rd_en), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp0 = rsp_cnt; wr0 = wr_cnt; rd0 = rd_cnt;
        check("mid_rst_ready", 32'(op_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rd_en", 32'(uart_rx_rd_en), 32'd0);
        check("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        flush_rx();
        repeat (5) @(posedge clk);
        #1;
        check("mid_rst_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
        check("mid_rst_no_strobes", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);
        v = '{1'b1, 8'h00, 1'b1, 1'b1, 0, 8'h24, 0, 0, 8'h24, 2'b00, 4, 1};
        run_op("after_rst", v);

        // op_valid held high: receives of 0x42 take 5 cycles each, one accept per IDLE visit
        echo_en = 1'b1; echo_on_accept = 1'b1; echo_delay = 0; echo_byte = 8'h42;
        op_type = 1'b1;
        acc0 = acc_cnt; rsp0 = rsp_cnt;
        ready_hi = 0; overlap = 0;
        op_valid = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (op_ready) ready_hi++;
            if (op_ready == busy) overlap++;
            if (rsp_valid) begin
                check("b2b_data", 32'(rsp_data), 32'h42);
                check("b2b_status", 32'(rsp_status), 32'd0);
                check("b2b_ready_in_respond", 32'(op_ready), 32'd0);
            end
        end
        op_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b2b_accepts", 32'(acc_cnt - acc0), 32'd3);
        check("b2b_responses", 32'(rsp_cnt - rsp0), 32'd3);
        check("b2b_ready_samples", 32'(ready_hi), 32'd3);
        check("b2b_ready_vs_busy", 32'(overlap), 32'd0);
        flush_rx();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
